// File: rtl/pattern_sweep_pkg.sv
// Shared types and MISR arithmetic for the pattern sweep capture block.
package pattern_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_EMIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [15:0] DEFAULT_POLY = 16'h1021;

    // Signatures up to this width go through the shared step function.
    localparam int MAX_SIG_W = 64;

    function automatic logic [MAX_SIG_W-1:0] misr_step(
        input logic [MAX_SIG_W-1:0] sig,
        input logic [MAX_SIG_W-1:0] poly,
        input logic [MAX_SIG_W-1:0] din,
        input int                   w
    );
        logic [MAX_SIG_W-1:0] mask;
        logic                 msb;
        logic [MAX_SIG_W-1:0] nxt;
        mask = (w >= MAX_SIG_W) ? '1 : ((64'd1 << w) - 64'd1);
        msb  = |(sig & (64'd1 << (w - 1)));
        nxt  = (sig << 1) ^ (msb ? poly : '0) ^ din;
        return nxt & mask;
    endfunction

endpackage

// File: rtl/pattern_sweep_capture_if.sv
// Capture-record handshake between the sweep engine and its consumer.
interface pattern_sweep_capture_if #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 1
);
    logic             rec_valid;
    logic             rec_ready;
    logic [IN_W-1:0]  rec_pat;
    logic [OUT_W-1:0] rec_resp;

    modport master (output rec_valid, output rec_pat, output rec_resp, input  rec_ready);
    modport slave  (input  rec_valid, input  rec_pat, input  rec_resp, output rec_ready);
endinterface

// File: rtl/misr_accum.sv
// Multiple-input signature register folding one response word per enable.
module misr_accum
    import pattern_sweep_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter int               OUT_W = 1,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY)
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [OUT_W-1:0] din,
    output logic [SIG_W-1:0] sig
);
    logic [SIG_W-1:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr)
            sig_d = '0;
        else if (en)
            sig_d = SIG_W'(misr_step(MAX_SIG_W'(sig_q), MAX_SIG_W'(POLY),
                                     MAX_SIG_W'(din), SIG_W));
    end

    always_ff @(posedge CK) begin
        if (reset) sig_q <= '0;
        else       sig_q <= sig_d;
    end

    assign sig = sig_q;
endmodule

// File: rtl/pattern_sweep_capture.sv
// Walks stim through 0..2^IN_W-1, samples resp after SETTLE cycles, emits one
// record per pattern over a valid/ready handshake and compresses responses into a MISR.
module pattern_sweep_capture
    import pattern_sweep_pkg::*;
#(
    parameter int               IN_W   = 4,
    parameter int               OUT_W  = 1,
    parameter int               SETTLE = 1,
    parameter int               SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEFAULT_POLY)
) (
    input  logic                    CK,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    output logic [IN_W-1:0]         stim,
    input  logic [OUT_W-1:0]        resp,
    pattern_sweep_capture_if.master rec,
    output logic                    busy,
    output logic                    done,
    output logic [SIG_W-1:0]        signature
);
    state_e           state_q, state_d;
    logic [IN_W-1:0]  stim_q, stim_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             rec_valid_q, rec_valid_d;
    logic [IN_W-1:0]  rec_pat_q, rec_pat_d;
    logic [OUT_W-1:0] rec_resp_q, rec_resp_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             misr_clr, misr_en;

    always_comb begin
        state_d     = state_q;
        stim_d      = stim_q;
        cnt_d       = cnt_q;
        rec_valid_d = rec_valid_q;
        rec_pat_d   = rec_pat_q;
        rec_resp_d  = rec_resp_q;
        misr_clr    = 1'b0;
        misr_en     = 1'b0;

        if (abort) begin
            // Record contents and signature are left as they were for post-mortem.
            state_d     = ST_IDLE;
            stim_d      = '0;
            cnt_d       = '0;
            rec_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_d  = ST_SETTLE;
                        stim_d   = '0;
                        cnt_d    = 8'(SETTLE);
                        misr_clr = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q <= 8'd1) begin
                        state_d     = ST_EMIT;
                        cnt_d       = '0;
                        rec_pat_d   = stim_q;
                        rec_resp_d  = resp;
                        rec_valid_d = 1'b1;
                        misr_en     = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                ST_EMIT: begin
                    if (rec.rec_ready) begin
                        rec_valid_d = 1'b0;
                        if (stim_q == '1) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_SETTLE;
                            stim_d  = stim_q + 1'b1;
                            cnt_d   = 8'(SETTLE);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_SETTLE) || (state_d == ST_EMIT);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge CK) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            stim_q      <= '0;
            cnt_q       <= '0;
            rec_valid_q <= 1'b0;
            rec_pat_q   <= '0;
            rec_resp_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            stim_q      <= stim_d;
            cnt_q       <= cnt_d;
            rec_valid_q <= rec_valid_d;
            rec_pat_q   <= rec_pat_d;
            rec_resp_q  <= rec_resp_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    misr_accum #(
        .SIG_W (SIG_W),
        .OUT_W (OUT_W),
        .POLY  (POLY)
    ) u_misr (
        .CK    (CK),
        .reset (reset),
        .clr   (misr_clr),
        .en    (misr_en),
        .din   (rec_resp_d),
        .sig   (signature)
    );

    assign stim          = stim_q;
    assign rec.rec_valid = rec_valid_q;
    assign rec.rec_pat   = rec_pat_q;
    assign rec.rec_resp  = rec_resp_q;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule
